vga_dac_port_ctrl: RTL and testbench
====================================

Name: vga_dac_port_ctrl

Overview:
- CPU-side controller for the VGA DAC palette. Decodes I/O accesses to the DAC registers 3C6h–3C9h.
- Sequences R/G/B component accesses with auto-incrementing read and write indices.
- Drives the byte-wide port A of the dual-port palette SRAM: 1024 x 8 addressing, address = {index[7:0], comp[1:0]}. The video side reads 256 x 32 from port B.
- Sits between the CPU I/O bus decoder and the palette SRAM.

Parameters:
- RAM_RD_LAT, 1, SRAM port A read latency in clocks (bypass read mode). Legal values: 1 or 2.
- PEL_MASK_RST, 8'hFF, reset value of the PEL mask register.

Ports:
- clk  in  1  system clock; also drives SRAM port A.
- rst  in  1  asynchronous, active-high reset.
- io_req  in  1  single-cycle access strobe.
- io_wr  in  1  1 = write, 0 = read; sampled with io_req.
- io_port  in  2  0 = 3C6h mask, 1 = 3C7h, 2 = 3C8h, 3 = 3C9h.
- io_din  in  8  write data.
- io_dout  out  8  read data; valid while io_ack is high.
- io_ack  out  1  one-cycle completion pulse.
- io_busy  out  1  high from io_req until io_ack, inclusive of neither.
- ram_ad  out  10  SRAM port A address {idx, comp}.
- ram_din  out  8  SRAM port A write data.
- ram_dout  in  8  SRAM port A read data.
- ram_ce  out  1  SRAM port A clock enable.
- ram_wre  out  1  SRAM port A write enable.
- ram_oce  out  1  SRAM port A output clock enable; tied to 1.
- pel_mask  out  8  PEL mask register, to the video pixel path.

Behaviour:
- Reset values:
  - wr_idx = 0, rd_idx = 0, comp = 0, dac_state = 2'b00.
  - pel_mask = PEL_MASK_RST.
  - io_dout = 0, io_ack = 0, io_busy = 0.
  - ram_ce = 0, ram_wre = 0, ram_ad = 0, ram_din = 0.
- FSM states: IDLE, WR_RAM, RD_WAIT, ACK.
  - io_req is accepted only in IDLE. An io_req seen in any other state is ignored: no ack, no state change.
- Write to 3C6h: pel_mask <= io_din.
- Write to 3C7h: rd_idx <= io_din, comp <= 0, dac_state <= 2'b11 (read mode).
- Write to 3C8h: wr_idx <= io_din, comp <= 0, dac_state <= 2'b00 (write mode).
- For all three writes above: io_ack pulses on the next cycle (latency 1).
- Write to 3C9h:
  - Enter WR_RAM: ram_ce = 1, ram_wre = 1, ram_ad = {wr_idx, comp}, ram_din = {2'b00, io_din[5:0]} for exactly one cycle.
  - Then ACK.
  - comp advances 0→1→2. On 2→0, wr_idx increments mod 256 (255 wraps to 0).
- Read of 3C9h:
  - Drive ram_ce = 1, ram_wre = 0, ram_ad = {rd_idx, comp}.
  - Hold RD_WAIT for RAM_RD_LAT cycles.
  - In ACK, io_dout = {2'b00, ram_dout[5:0]} and io_ack = 1.
  - comp/rd_idx advance with the same rule as writes.
  - Total latency is RAM_RD_LAT + 1 cycles.
- Register reads, all acked after 1 cycle:
  - 3C6h returns pel_mask.
  - 3C7h returns {6'b0, dac_state}.
  - 3C8h returns wr_idx.
- 3C9h write while in read mode (and read while in write mode) is legal. Each direction uses its own index, but both share comp.
- comp never takes the value 3, so SRAM address slot 3 of each entry is never touched.
- Reset asserted mid-operation:
  - Return to IDLE immediately.
  - No ack is issued; ram_wre drops.
  - An interrupted write may or may not have landed in the SRAM.
- io_dout holds its value between acks.

Optional Feature:
- Macro VGA_DAC_8BIT_EN.
- Defined: components are full 8-bit. ram_din = io_din and 3C9h reads return ram_dout unmasked.
- Undefined: 6-bit VGA DAC behaviour as described above. Upper two bits are zero on write and forced to zero on read.

Decomposition:
- Shared package vga_dac_pkg holds:
  - Port-select constants: DAC_PORT_MASK = 0, DAC_PORT_RIDX = 1, DAC_PORT_WIDX = 2, DAC_PORT_DATA = 3.
  - FSM state typedef.
  - dac_state encodings: DAC_ST_WRITE = 2'b00, DAC_ST_READ = 2'b11.
- One sub-module, vga_dac_idx_seq: the index/comp auto-increment counter, instantiated twice (read and write pointers). comp is a shared register outside it, so the sub-module provides only the index increment-on-wrap logic.

Test Plan:
- Reset, then read 3C6h, 3C7h, 3C8h → 8'hFF, 8'h00, 8'h00, each with io_ack exactly 1 cycle after io_req.
- Write 3C8h = 8'h10, then write 3C9h with 8'h3F, 8'h20, 8'h01 → SRAM writes at addresses 10'h040, 10'h041, 10'h042 with those data; then read 3C8h → 8'h11.
- Write 3C8h = 8'hFF, then three 3C9h writes → last write at address 10'h3FE; read 3C8h → 8'h00 (wrap).
- Preload entry 5 = {R 2A, G 15, B 3F}; write 3C7h = 5; three 3C9h reads → 2A, 15, 3F, each ack at RAM_RD_LAT + 1 cycles; then read 3C7h → 8'h03.
- Write 3C9h = 8'hFF → SRAM data 8'h3F without VGA_DAC_8BIT_EN, 8'hFF with it; an io_req issued while io_busy is high is dropped (no extra ack, indices unchanged).
- Assert rst during RD_WAIT → no io_ack; all outputs return to reset values asynchronously; pel_mask = 8'hFF.

Source files
------------

// File: rtl/vga_dac_pkg.sv
// Shared definitions for the VGA DAC CPU-side port controller.
//   - I/O port selectors for 3C6h..3C9h
//   - dac_state encodings reported through 3C7h
//   - controller FSM state type
//   - component formatting helper, shaped by the optional macro
//     VGA_DAC_8BIT_EN (defined: full 8-bit components; undefined: 6-bit
//     VGA components with the upper two bits forced to zero)
package vga_dac_pkg;

    localparam logic [1:0] DAC_PORT_MASK = 2'd0;
    localparam logic [1:0] DAC_PORT_RIDX = 2'd1;
    localparam logic [1:0] DAC_PORT_WIDX = 2'd2;
    localparam logic [1:0] DAC_PORT_DATA = 2'd3;

    localparam logic [1:0] DAC_ST_WRITE = 2'b00;
    localparam logic [1:0] DAC_ST_READ  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_RAM  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_ACK     = 2'd3
    } dac_fsm_e;

    // Component width shaping, applied both on SRAM writes and 3C9h reads.
    function automatic logic [7:0] dac_comp_fmt(input logic [7:0] v);
`ifdef VGA_DAC_8BIT_EN
        return v;
`else
        return {2'b00, v[5:0]};
`endif
    endfunction

    // R -> G -> B -> R; the value 3 is never produced.
    function automatic logic [1:0] comp_next(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : (c + 2'd1);
    endfunction

endpackage

// File: rtl/vga_dac_idx_seq.sv
// Palette index pointer with auto-increment.
// The component counter lives in the parent and is shared between the read
// and write pointers; this block only advances the index when the parent
// reports a B -> R wrap of that shared counter.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   load_i           load load_val_i (3C7h / 3C8h write)
//   load_val_i [8]   new index value
//   wrap_i           component counter wrapped for this pointer's access
//   idx_o [8]        current index
module vga_dac_idx_seq (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       wrap_i,
    output logic [7:0] idx_o
);

    logic [7:0] idx_q;

    // Index register: load has priority over increment; 255 wraps to 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= 8'd0;
        end else if (load_i) begin
            idx_q <= load_val_i;
        end else if (wrap_i) begin
            idx_q <= idx_q + 8'd1;
        end else begin
            idx_q <= idx_q;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/vga_dac_port_ctrl.sv
// CPU-side VGA DAC palette controller. Decodes accesses to 3C6h..3C9h and
// drives byte-wide port A of the palette SRAM at address {index, comp}.
// Optional macro: VGA_DAC_8BIT_EN (full 8-bit components when defined).
// Ports:
//   clk, rst                        clock, async active-high reset
//   io_req/io_wr/io_port/io_din     CPU access strobe, direction, port, data
//   io_dout/io_ack/io_busy          read data, completion pulse, in-progress
//   ram_ad/ram_din/ram_dout         SRAM port A address and data
//   ram_ce/ram_wre/ram_oce          SRAM port A enables (oce tied high)
//   pel_mask                        PEL mask register to the pixel path
module vga_dac_port_ctrl
    import vga_dac_pkg::*;
#(
    parameter int         RAM_RD_LAT   = 1,
    parameter logic [7:0] PEL_MASK_RST = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_req,
    input  logic       io_wr,
    input  logic [1:0] io_port,
    input  logic [7:0] io_din,
    output logic [7:0] io_dout,
    output logic       io_ack,
    output logic       io_busy,
    output logic [9:0] ram_ad,
    output logic [7:0] ram_din,
    input  logic [7:0] ram_dout,
    output logic       ram_ce,
    output logic       ram_wre,
    output logic       ram_oce,
    output logic [7:0] pel_mask
);

    dac_fsm_e   state_q, state_d;
    logic [1:0] comp_q, comp_d;
    logic [1:0] dac_st_q, dac_st_d;
    logic [7:0] pel_mask_q, pel_mask_d;
    logic [7:0] io_dout_q, io_dout_d;
    logic       io_ack_q, io_ack_d;
    logic       io_busy_q;
    logic       rd_ack_q, rd_ack_d;
    logic       wait_q, wait_d;
    logic       ram_ce_q, ram_ce_d;
    logic       ram_wre_q, ram_wre_d;
    logic [9:0] ram_ad_q, ram_ad_d;
    logic [7:0] ram_din_q, ram_din_d;

    logic       wr_load_s, rd_load_s, wr_wrap_s, rd_wrap_s;
    logic [7:0] wr_idx_s, rd_idx_s;
    logic       last_wait_s;

    vga_dac_idx_seq u_wr_idx (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (wr_load_s),
        .load_val_i (io_din),
        .wrap_i     (wr_wrap_s),
        .idx_o      (wr_idx_s)
    );

    vga_dac_idx_seq u_rd_idx (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (rd_load_s),
        .load_val_i (io_din),
        .wrap_i     (rd_wrap_s),
        .idx_o      (rd_idx_s)
    );

    assign last_wait_s = (wait_q == 1'(RAM_RD_LAT - 1));

    // Next-state and registered-output decode for the access sequencer.
    always_comb begin
        state_d    = state_q;
        comp_d     = comp_q;
        dac_st_d   = dac_st_q;
        pel_mask_d = pel_mask_q;
        io_dout_d  = io_dout_q;
        io_ack_d   = 1'b0;
        rd_ack_d   = 1'b0;
        wait_d     = 1'b0;
        ram_ce_d   = 1'b0;
        ram_wre_d  = 1'b0;
        ram_ad_d   = ram_ad_q;
        ram_din_d  = ram_din_q;
        wr_load_s  = 1'b0;
        rd_load_s  = 1'b0;
        wr_wrap_s  = 1'b0;
        rd_wrap_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (io_req) begin
                    // Register accesses complete through ACK on the next cycle.
                    state_d  = ST_ACK;
                    io_ack_d = 1'b1;
                    if (io_wr) begin
                        case (io_port)
                            DAC_PORT_MASK: pel_mask_d = io_din;
                            DAC_PORT_RIDX: begin
                                rd_load_s = 1'b1;
                                comp_d    = 2'd0;
                                dac_st_d  = DAC_ST_READ;
                            end
                            DAC_PORT_WIDX: begin
                                wr_load_s = 1'b1;
                                comp_d    = 2'd0;
                                dac_st_d  = DAC_ST_WRITE;
                            end
                            DAC_PORT_DATA: begin
                                state_d   = ST_WR_RAM;
                                io_ack_d  = 1'b0;
                                ram_ce_d  = 1'b1;
                                ram_wre_d = 1'b1;
                                ram_ad_d  = {wr_idx_s, comp_q};
                                ram_din_d = dac_comp_fmt(io_din);
                                comp_d    = comp_next(comp_q);
                                wr_wrap_s = (comp_q == 2'd2);
                            end
                            default: state_d = ST_IDLE;
                        endcase
                    end else begin
                        case (io_port)
                            DAC_PORT_MASK: io_dout_d = pel_mask_q;
                            DAC_PORT_RIDX: io_dout_d = {6'd0, dac_st_q};
                            DAC_PORT_WIDX: io_dout_d = wr_idx_s;
                            DAC_PORT_DATA: begin
                                state_d   = ST_RD_WAIT;
                                io_ack_d  = 1'b0;
                                ram_ce_d  = 1'b1;
                                ram_ad_d  = {rd_idx_s, comp_q};
                                comp_d    = comp_next(comp_q);
                                rd_wrap_s = (comp_q == 2'd2);
                            end
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_RAM: begin
                state_d  = ST_ACK;
                io_ack_d = 1'b1;
            end
            ST_RD_WAIT: begin
                if (last_wait_s) begin
                    state_d  = ST_ACK;
                    io_ack_d = 1'b1;
                    rd_ack_d = 1'b1;
                end else begin
                    // Keep the port clocked so the output register can load.
                    ram_ce_d = 1'b1;
                    wait_d   = wait_q + 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                if (rd_ack_q) begin
                    io_dout_d = dac_comp_fmt(ram_dout);
                end else begin
                    io_dout_d = io_dout_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            comp_q     <= 2'd0;
            dac_st_q   <= DAC_ST_WRITE;
            pel_mask_q <= PEL_MASK_RST;
            io_dout_q  <= 8'd0;
            io_ack_q   <= 1'b0;
            io_busy_q  <= 1'b0;
            rd_ack_q   <= 1'b0;
            wait_q     <= 1'b0;
            ram_ce_q   <= 1'b0;
            ram_wre_q  <= 1'b0;
            ram_ad_q   <= 10'd0;
            ram_din_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            comp_q     <= comp_d;
            dac_st_q   <= dac_st_d;
            pel_mask_q <= pel_mask_d;
            io_dout_q  <= io_dout_d;
            io_ack_q   <= io_ack_d;
            io_busy_q  <= (state_d == ST_WR_RAM) || (state_d == ST_RD_WAIT);
            rd_ack_q   <= rd_ack_d;
            wait_q     <= wait_d;
            ram_ce_q   <= ram_ce_d;
            ram_wre_q  <= ram_wre_d;
            ram_ad_q   <= ram_ad_d;
            ram_din_q  <= ram_din_d;
        end
    end

    // SRAM data only becomes valid in the ACK cycle itself, so a palette read
    // is passed straight through then and captured for holding afterwards.
    assign io_dout  = rd_ack_q ? dac_comp_fmt(ram_dout) : io_dout_q;
    assign io_ack   = io_ack_q;
    assign io_busy  = io_busy_q;
    assign ram_ad   = ram_ad_q;
    assign ram_din  = ram_din_q;
    assign ram_ce   = ram_ce_q;
    assign ram_wre  = ram_wre_q;
    assign ram_oce  = 1'b1;
    assign pel_mask = pel_mask_q;

endmodule

// File: tb/tb_vga_dac_port_ctrl.sv
// Self-checking bench for vga_dac_port_ctrl: directed vector table,
// hand-written busy-drop and reset-abort sequences, and random accesses
// checked against a behavioural palette model.
module tb_vga_dac_port_ctrl;

    localparam int LAT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       io_req, io_wr;
    logic [1:0] io_port;
    logic [7:0] io_din, io_dout;
    logic       io_ack, io_busy;
    logic [9:0] ram_ad;
    logic [7:0] ram_din, ram_dout;
    logic       ram_ce, ram_wre, ram_oce;
    logic [7:0] pel_mask;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vga_dac_port_ctrl #(.RAM_RD_LAT(LAT), .PEL_MASK_RST(8'hFF)) dut (
        .clk(clk), .rst(rst), .io_req(io_req), .io_wr(io_wr),
        .io_port(io_port), .io_din(io_din), .io_dout(io_dout),
        .io_ack(io_ack), .io_busy(io_busy), .ram_ad(ram_ad),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_ce(ram_ce),
        .ram_wre(ram_wre), .ram_oce(ram_oce), .pel_mask(pel_mask)
    );

    // ---------------- SRAM port A model ----------------
    logic [7:0] init_pal [1024];
    logic [7:0] sram [1024];
    bit         sram_v [1024];
    logic [7:0] rd_s1, rd_s2;
    logic [17:0] wq [$];

    always @(posedge clk) begin
        if (ram_ce === 1'b1) begin
            if (ram_wre === 1'b1) begin
                sram[ram_ad]   <= ram_din;
                sram_v[ram_ad] <= 1'b1;
                wq.push_back({ram_ad, ram_din});
            end else begin
                rd_s1 <= sram_v[ram_ad] ? sram[ram_ad] : init_pal[ram_ad];
            end
            if (ram_oce === 1'b1) rd_s2 <= rd_s1;
        end
    end
    assign ram_dout = (LAT == 2) ? rd_s2 : rd_s1;

    // ---------------- reference model ----------------
    logic [7:0] ref_pel, ref_widx, ref_ridx;
    int         ref_comp;
    bit         ref_rmode;
    logic [7:0] ref_pal [256][3];

    function automatic logic [7:0] fmt(input logic [7:0] v);
`ifdef VGA_DAC_8BIT_EN
        return v;
`else
        return {2'b00, v[5:0]};
`endif
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        ref_pel = 8'hFF; ref_widx = 8'h00; ref_ridx = 8'h00;
        ref_comp = 0; ref_rmode = 1'b0;
    endfunction

    function automatic void model_adv(input bit is_wr);
        ref_comp++;
        if (ref_comp == 3) begin
            ref_comp = 0;
            if (is_wr) ref_widx = ref_widx + 8'd1;
            else       ref_ridx = ref_ridx + 8'd1;
        end
    endfunction

    // One complete CPU access, checked against the model, then model update.
    task automatic access(input bit wr, input logic [1:0] port,
                          input logic [7:0] din, output logic [7:0] got);
        int exp_lat, lat;
        logic [7:0] exp_d, exp_wd;
        logic [9:0] exp_a;
        exp_lat = (port == 2'd3) ? (wr ? 2 : LAT + 1) : 1;
        case (port)
            2'd0:    exp_d = ref_pel;
            2'd1:    exp_d = ref_rmode ? 8'h03 : 8'h00;
            2'd2:    exp_d = ref_widx;
            default: exp_d = fmt(ref_pal[ref_ridx][ref_comp]);
        endcase
        exp_a  = {ref_widx, 2'(ref_comp)};
        exp_wd = fmt(din);
        wq.delete();
        @(posedge clk); #1;
        io_req = 1'b1; io_wr = wr; io_port = port; io_din = din;
        @(posedge clk); #1;
        io_req = 1'b0;
        lat = 0; got = 8'h00;
        for (int n = 1; n <= 12; n++) begin
            if (io_ack === 1'b1) begin
                lat = n; got = io_dout;
                break;
            end
            @(posedge clk); #1;
        end
        check("ack_latency", lat, exp_lat);
        if (!wr) check("read_data", int'(got), int'(exp_d));
        @(posedge clk); #1;
        check("ack_single", int'(io_ack), 0);
        if (wr && port == 2'd3) begin
            check("ram_wr_count", wq.size(), 1);
            if (wq.size() > 0) check("ram_wr", int'(wq[0]), int'({exp_a, exp_wd}));
        end else begin
            check("ram_wr_count", wq.size(), 0);
        end
        if (wr) begin
            case (port)
                2'd0: ref_pel = din;
                2'd1: begin ref_ridx = din; ref_comp = 0; ref_rmode = 1'b1; end
                2'd2: begin ref_widx = din; ref_comp = 0; ref_rmode = 1'b0; end
                default: begin
                    ref_pal[ref_widx][ref_comp] = exp_wd;
                    model_adv(1'b1);
                end
            endcase
        end else if (port == 2'd3) begin
            model_adv(1'b0);
        end
    endtask

    typedef struct {
        bit         wr;
        logic [1:0] port;
        logic [7:0] din;
        bit         chk;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [$];

    function automatic void add(input bit wr, input logic [1:0] port,
                                input logic [7:0] din, input bit chk,
                                input logic [7:0] exp);
        vec_t v;
        v.wr = wr; v.port = port; v.din = din; v.chk = chk; v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [7:0] got;
        logic [9:0] exp_a;
        logic [7:0] exp_wd;
        int         late_acks;

        io_req = 1'b0; io_wr = 1'b0; io_port = 2'd0; io_din = 8'h00;
        for (int i = 0; i < 1024; i++) init_pal[i] = 8'($urandom);
        init_pal[20] = 8'h2A; init_pal[21] = 8'h15; init_pal[22] = 8'h3F;
        for (int i = 0; i < 256; i++)
            for (int c = 0; c < 3; c++) ref_pal[i][c] = init_pal[i*4 + c];
        model_reset();

        add(1'b0, 2'd0, 8'h00, 1'b1, 8'hFF);
        add(1'b0, 2'd1, 8'h00, 1'b1, 8'h00);
        add(1'b0, 2'd2, 8'h00, 1'b1, 8'h00);
        add(1'b1, 2'd2, 8'h10, 1'b0, 8'h00);
        add(1'b1, 2'd3, 8'h3F, 1'b0, 8'h00);
        add(1'b1, 2'd3, 8'h20, 1'b0, 8'h00);
        add(1'b1, 2'd3, 8'h01, 1'b0, 8'h00);
        add(1'b0, 2'd2, 8'h00, 1'b1, 8'h11);
        add(1'b1, 2'd2, 8'hFF, 1'b0, 8'h00);
        add(1'b1, 2'd3, 8'h11, 1'b0, 8'h00);
        add(1'b1, 2'd3, 8'h22, 1'b0, 8'h00);
        add(1'b1, 2'd3, 8'h33, 1'b0, 8'h00);
        add(1'b0, 2'd2, 8'h00, 1'b1, 8'h00);
        add(1'b1, 2'd1, 8'h05, 1'b0, 8'h00);
        add(1'b0, 2'd3, 8'h00, 1'b1, 8'h2A);
        add(1'b0, 2'd3, 8'h00, 1'b1, 8'h15);
        add(1'b0, 2'd3, 8'h00, 1'b1, 8'h3F);
        add(1'b0, 2'd1, 8'h00, 1'b1, 8'h03);
        add(1'b1, 2'd3, 8'hFF, 1'b0, 8'h00);
        add(1'b1, 2'd0, 8'h5A, 1'b0, 8'h00);
        add(1'b0, 2'd0, 8'h00, 1'b1, 8'h5A);

        // Power-on reset state.
        rst = 1'b1;
        #12;
        check("rst_ack", int'(io_ack), 0);
        check("rst_busy", int'(io_busy), 0);
        check("rst_dout", int'(io_dout), 0);
        check("rst_ce_wre", int'({ram_ce, ram_wre}), 0);
        check("rst_ad_din", int'({ram_ad, ram_din}), 0);
        check("rst_mask", int'(pel_mask), 8'hFF);
        check("oce", int'(ram_oce), 1);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            access(vecs[i].wr, vecs[i].port, vecs[i].din, got);
            if (vecs[i].chk) check("table_vec", int'(got), int'(vecs[i].exp));
        end
        check("pel_mask_port", int'(pel_mask), 8'h5A);

        // A request raised while busy is dropped.
        exp_a  = {ref_widx, 2'(ref_comp)};
        exp_wd = fmt(8'hC5);
        wq.delete();
        @(posedge clk); #1;
        io_req = 1'b1; io_wr = 1'b1; io_port = 2'd3; io_din = 8'hC5;
        @(posedge clk); #1;
        check("busy_in_write", int'(io_busy), 1);
        io_port = 2'd2; io_din = 8'h77;
        @(posedge clk); #1;
        io_req = 1'b0;
        check("drop_ack", int'(io_ack), 1);
        check("drop_busy_at_ack", int'(io_busy), 0);
        late_acks = 0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (io_ack === 1'b1) late_acks++;
        end
        check("drop_no_extra_ack", late_acks, 0);
        check("drop_ram_wr_count", wq.size(), 1);
        if (wq.size() > 0) check("drop_ram_wr", int'(wq[0]), int'({exp_a, exp_wd}));
        ref_pal[ref_widx][ref_comp] = exp_wd;
        model_adv(1'b1);
        access(1'b0, 2'd2, 8'h00, got);

        // Random traffic against the model.
        for (int k = 0; k < 150; k++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   8'($urandom), got);
        end

        // Reset in the middle of a palette read.
        access(1'b1, 2'd0, 8'h3C, got);
        @(posedge clk); #1;
        io_req = 1'b1; io_wr = 1'b0; io_port = 2'd3;
        @(posedge clk); #1;
        io_req = 1'b0;
        check("busy_in_read", int'(io_busy), 1);
        rst = 1'b1;
        #1;
        check("abort_ack", int'(io_ack), 0);
        check("abort_busy", int'(io_busy), 0);
        check("abort_ce_wre", int'({ram_ce, ram_wre}), 0);
        check("abort_ad_din", int'({ram_ad, ram_din}), 0);
        check("abort_dout", int'(io_dout), 0);
        check("abort_mask", int'(pel_mask), 8'hFF);
        late_acks = 0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (io_ack === 1'b1) late_acks++;
        end
        check("abort_no_ack", late_acks, 0);
        rst = 1'b0;
        model_reset();
        access(1'b0, 2'd0, 8'h00, got);
        access(1'b0, 2'd2, 8'h00, got);
        access(1'b0, 2'd1, 8'h00, got);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
